// File: rtl/ahb_fifo_arbiter_if.sv
// Request/grant bundle between the NMASTER requesters and the AHB-FIFO arbiter.
// A request is level-held on hbusreq until the master sees its hgrant bit, and a transfer beat is accepted only on a hready-high edge.
interface ahb_fifo_arbiter_if #(
  parameter int NMASTER = 4,
  parameter int MW      = $clog2(NMASTER)
);
  logic [NMASTER-1:0] hbusreq;
  logic [NMASTER-1:0] hreqwr;
  logic [NMASTER-1:0] hlock;
  logic [1:0]         htrans;
  logic [2:0]         hburst;
  logic               hready;
  logic               wfull;
  logic               rempty;
  logic [NMASTER-1:0] hgrant;
  logic [MW-1:0]      hmaster;
  logic               hmastlock;

  modport slave (
    input  hbusreq, hreqwr, hlock, htrans, hburst, hready, wfull, rempty,
    output hgrant, hmaster, hmastlock
  );

  modport master (
    output hbusreq, hreqwr, hlock, htrans, hburst, hready, wfull, rempty,
    input  hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_fifo_arbiter.sv
// Round-robin AHB arbiter for the shared AHB-FIFO slave port: FIFO-aware
// eligibility, defined-length burst tracking and locked-sequence hold.
module ahb_fifo_arbiter #(
  parameter int NMASTER = 4,
  parameter int MW      = $clog2(NMASTER)
) (
  input  logic                     hclk,
  input  logic                     hreset,
  ahb_fifo_arbiter_if.slave        bus,
  output logic [1:0]               dbg_state
);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ADDR  = 2'd1,
    BURST = 2'd2,
    LOCK  = 2'd3
  } state_t;

  state_t             state;
  logic [4:0]         beat_cnt;
  logic [4:0]         burst_len;
  logic [MW-1:0]      last_idx;
  logic [MW-1:0]      own_idx;
  logic [MW-1:0]      win_idx;
  logic [NMASTER-1:0] win_oh;
  logic               win_vld;
  logic               last_beat;
  logic [NMASTER-1:0] eligible;

  assign dbg_state = state;

  assign eligible = bus.hbusreq
                  & ~(bus.hreqwr & {NMASTER{bus.wfull}})
                  & ~(~bus.hreqwr & {NMASTER{bus.rempty}});

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NMASTER; i++) begin
      if (bus.hgrant[i]) own_idx = MW'(i);
    end
  end

  // Walk downward so the nearest index above last_idx is the final assignment.
  always_comb begin
    int            cand;
    logic [MW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    win_vld  = 1'b0;
    win_idx  = last_idx;
    for (int k = NMASTER; k >= 1; k--) begin
      cand = int'(last_idx) + k;
      if (cand >= NMASTER) cand = cand - NMASTER;
      cand_idx = MW'(cand);
      if (eligible[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign win_oh = {{(NMASTER-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    case (bus.hburst)
      3'd0:       burst_len = 5'd1;
      3'd1:       burst_len = 5'd0;
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      default:    burst_len = 5'd16;
    endcase
  end

  assign last_beat = bus.hready &&
    ((state == ADDR  && bus.htrans == TR_NONSEQ && burst_len == 5'd1) ||
     (state == BURST && bus.htrans == TR_SEQ    && beat_cnt  == 5'd2));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state         <= ARB;
      beat_cnt      <= '0;
      last_idx      <= MW'(NMASTER - 1);
      bus.hgrant    <= {{(NMASTER-1){1'b0}}, 1'b1};
      bus.hmaster   <= '0;
      bus.hmastlock <= 1'b0;
    end else if (bus.hready) begin
      bus.hmaster   <= own_idx;
      bus.hmastlock <= bus.hlock[own_idx];
      case (state)
        ARB: begin
          if (win_vld) begin
            bus.hgrant <= win_oh;
            last_idx   <= win_idx;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (bus.htrans == TR_NONSEQ) begin
            beat_cnt <= burst_len;
            state    <= BURST;
          end else if (bus.htrans == TR_IDLE || !bus.hbusreq[own_idx]) begin
            state <= ARB;
          end
        end
        BURST: begin
          case (bus.htrans)
            TR_SEQ:  if (beat_cnt > 5'd1) beat_cnt <= beat_cnt - 5'd1;
            TR_BUSY: ;
            default: state <= ARB;
          endcase
        end
        LOCK: begin
          if (!bus.hlock[own_idx]) state <= ARB;
        end
        default: state <= ARB;
      endcase
      // Final beat hands the bus over on the same edge so no idle ARB cycle is inserted.
      if (last_beat) begin
        if (bus.hlock[own_idx]) begin
          state <= LOCK;
        end else if (win_vld) begin
          bus.hgrant <= win_oh;
          last_idx   <= win_idx;
          state      <= ADDR;
        end else begin
          state <= ARB;
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_fifo_arbiter.sv
// Bench for ahb_fifo_arbiter: scripted AHB master activity with a grant/hmaster
// scoreboard plus cycle-exact checks of bursts, masking, lock and reset.
module tb_ahb_fifo_arbiter;
  localparam int NM = 4;
  localparam int MW = 2;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam int ST_ARB = 0, ST_ADDR = 1, ST_BURST = 2, ST_LOCK = 3;

  logic          hclk;
  logic          hreset;
  logic [1:0]    dbg_state;
  logic [NM-1:0] prev_grant;
  logic [MW-1:0] prev_mst;
  logic [MW-1:0] gnt_q[$];
  logic [MW-1:0] mst_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  logic [1:0] b8_tr  [13] = '{TR_NONSEQ, TR_SEQ, TR_BUSY, TR_SEQ, TR_SEQ, TR_SEQ, TR_BUSY,
                              TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ};
  logic       b8_rdy [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                              1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  ahb_fifo_arbiter_if #(.NMASTER(NM), .MW(MW)) bus ();

  ahb_fifo_arbiter #(.NMASTER(NM), .MW(MW)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [NM-1:0] onehot(input logic [MW-1:0] m);
    onehot    = '0;
    onehot[m] = 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.hbusreq = '0;
    bus.hreqwr  = '0;
    bus.hlock   = '0;
    bus.htrans  = TR_IDLE;
    bus.hburst  = 3'd0;
    bus.hready  = 1'b1;
    bus.wfull   = 1'b0;
    bus.rempty  = 1'b0;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    set_idle();
    repeat (2) @(posedge hclk);
    #1;
    hreset     = 1'b0;
    prev_grant = bus.hgrant;
    prev_mst   = bus.hmaster;
  endtask

  task automatic expect_grant(input logic [MW-1:0] m);
    gnt_q.push_back(m);
    mst_q.push_back(m);
  endtask

  // One clock; every grant or hmaster change is matched against the scoreboard.
  task automatic tick();
    logic [MW-1:0] e;
    @(posedge hclk);
    #1;
    if (bus.hgrant !== prev_grant) begin
      if (gnt_q.size() == 0) check("grant_extra", 32'(bus.hgrant), 32'(prev_grant));
      else begin
        e = gnt_q.pop_front();
        check("grant_order", 32'(bus.hgrant), 32'(onehot(e)));
      end
      prev_grant = bus.hgrant;
    end
    if (bus.hmaster !== prev_mst) begin
      if (mst_q.size() == 0) check("hmaster_extra", 32'(bus.hmaster), 32'(prev_mst));
      else begin
        e = mst_q.pop_front();
        check("hmaster_order", 32'(bus.hmaster), 32'(e));
      end
      prev_mst = bus.hmaster;
    end
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_gnt_q_left"}, 32'(gnt_q.size()), 0);
    check({tag, "_mst_q_left"}, 32'(mst_q.size()), 0);
    gnt_q.delete();
    mst_q.delete();
  endtask

  initial begin
    hreset = 1'b1;
    set_idle();

    // Reset and idle parking on master 0
    do_reset();
    check("rst_grant", 32'(bus.hgrant), 1);
    check("rst_hmaster", 32'(bus.hmaster), 0);
    check("rst_hmastlock", 32'(bus.hmastlock), 0);
    check("rst_state", 32'(dbg_state), ST_ARB);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_grant", 32'(bus.hgrant), 1);
      check("idle_hmaster", 32'(bus.hmaster), 0);
      check("idle_hmastlock", 32'(bus.hmastlock), 0);
    end
    drain_check("idle");

    // Round robin over four reading masters with SINGLE transfers
    do_reset();
    bus.hbusreq = 4'b1111;
    bus.htrans  = TR_NONSEQ;
    expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_grant", 32'(bus.hgrant), 32'(onehot(MW'(i % NM))));
      check("rr_hmaster", 32'(bus.hmaster), (i == 0) ? 0 : i - 1);
    end
    set_idle();
    tick(); tick();
    drain_check("rr");

    // FIFO masking of writes by wfull and reads by rempty
    do_reset();
    bus.hbusreq = 4'b0001;
    bus.wfull   = 1'b1;
    tick();
    check("mask_m0_grant", 32'(bus.hgrant), 1);
    check("mask_m0_state", 32'(dbg_state), ST_ADDR);
    bus.hbusreq = 4'b0110;
    bus.hreqwr  = 4'b0010;
    tick();
    check("mask_addr_idle_state", 32'(dbg_state), ST_ARB);
    expect_grant(2);
    tick();
    check("mask_wr_skipped", 32'(bus.hgrant), 4);
    bus.wfull   = 1'b0;
    bus.hbusreq = 4'b0010;
    bus.htrans  = TR_NONSEQ;
    expect_grant(1);
    tick();
    check("mask_wr_open", 32'(bus.hgrant), 2);
    bus.htrans  = TR_IDLE;
    bus.hbusreq = 4'b0001;
    bus.hreqwr  = 4'b0000;
    bus.rempty  = 1'b1;
    tick(); tick();
    check("mask_rd_park", 32'(bus.hgrant), 2);
    bus.rempty = 1'b0;
    expect_grant(0);
    tick();
    check("mask_rd_open", 32'(bus.hgrant), 1);
    set_idle();
    tick(); tick();
    drain_check("mask");

    // INCR8 by master 0 with BUSY and wait states; handover on the 8th accept
    do_reset();
    bus.hbusreq = 4'b0011;
    tick();
    bus.hburst = 3'd5;
    for (int c = 0; c < 13; c++) begin
      bus.htrans = b8_tr[c];
      bus.hready = b8_rdy[c];
      if (c == 12) expect_grant(1);
      tick();
      check("incr8_grant", 32'(bus.hgrant), (c == 12) ? 2 : 1);
      if (c == 0) check("incr8_state", 32'(dbg_state), ST_BURST);
    end
    set_idle();
    tick(); tick();
    drain_check("incr8");

    // INCR16 terminated with IDLE after beat 5, then a stalled ARB cycle
    do_reset();
    bus.hbusreq = 4'b0101;
    tick();
    bus.hburst = 3'd7;
    bus.htrans = TR_NONSEQ;
    tick();
    check("early_state_burst", 32'(dbg_state), ST_BURST);
    bus.htrans = TR_SEQ;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("early_hold", 32'(bus.hgrant), 1);
    end
    bus.htrans = TR_IDLE;
    tick();
    check("early_state_arb", 32'(dbg_state), ST_ARB);
    check("early_grant_kept", 32'(bus.hgrant), 1);
    bus.hready = 1'b0;
    tick(); tick();
    check("stall_grant", 32'(bus.hgrant), 1);
    check("stall_state", 32'(dbg_state), ST_ARB);
    bus.hready = 1'b1;
    expect_grant(2);
    tick();
    check("early_next", 32'(bus.hgrant), 4);
    set_idle();
    tick(); tick();
    drain_check("early");

    // Locked master 3 keeps the bus across bursts; reset lands mid-burst
    do_reset();
    bus.hbusreq = 4'b1111;
    bus.hlock   = 4'b1000;
    bus.htrans  = TR_NONSEQ;
    expect_grant(1); expect_grant(2); expect_grant(3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lock_rr_grant", 32'(bus.hgrant), 32'(onehot(MW'(i))));
    end
    bus.hburst = 3'd3;
    for (int n = 0; n < 10; n++) begin
      bus.htrans = (n % 4 == 0) ? TR_NONSEQ : TR_SEQ;
      tick();
      check("lock_grant", 32'(bus.hgrant), 8);
      check("lock_hmastlock", 32'(bus.hmastlock), 1);
      if (n == 3) check("lock_state", 32'(dbg_state), ST_LOCK);
    end
    drain_check("lock");
    #2;
    hreset = 1'b1;
    #1;
    check("rst_mid_grant", 32'(bus.hgrant), 1);
    check("rst_mid_hmaster", 32'(bus.hmaster), 0);
    check("rst_mid_hmastlock", 32'(bus.hmastlock), 0);
    check("rst_mid_state", 32'(dbg_state), ST_ARB);
    do_reset();
    tick();
    check("post_rst_grant", 32'(bus.hgrant), 1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_fifo_arbiter.md
Name: ahb_fifo_arbiter

Overview:
- Round-robin AHB bus arbiter that shares the single AHB-FIFO slave port among NMASTER requesters.
- Grants the bus only to requesters whose intended transfer can proceed, given FIFO status: writes are masked while wfull, reads while rempty.
- Tracks defined-length bursts so that a grant is never revoked mid-burst, and honours locked sequences.
- Drives the grant vectors, hmaster and hmastlock for the external master mux that feeds the FIFO interface.

Parameters:
- NMASTER, 4, number of requesting masters (2..8).
- MW, 2, width of hmaster; equals clog2(NMASTER).

Ports:
- hclk  input  1  bus clock; all state updates on its rising edge.
- hreset  input  1  asynchronous, active-high reset.
- hbusreq  input  NMASTER  per-master bus request, level-held until granted.
- hreqwr  input  NMASTER  per-master direction of pending request (1 = write, 0 = read); valid while hbusreq is high.
- hlock  input  NMASTER  per-master locked-transfer request.
- htrans  input  2  transfer type from the currently selected master (post-mux).
- hburst  input  3  burst type from the currently selected master (post-mux).
- hready  input  1  slave ready.
- wfull  input  1  FIFO write side full.
- rempty  input  1  FIFO read side empty.
- hgrant  output  NMASTER  one-hot grant, registered.
- hmaster  output  MW  index of the master owning the address phase, registered.
- hmastlock  output  1  current transfer is locked, registered.

Behaviour:
- Reset values (asynchronous, while hreset is high):
  - hgrant = 1 (master 0 parked).
  - hmaster = 0, hmastlock = 0.
  - state = ARB, beat counter = 0.
  - Round-robin pointer set so master 0 has highest priority.
- Eligibility: eligible[i] = hbusreq[i] & ~(hreqwr[i] & wfull) & ~(~hreqwr[i] & rempty).
- Selection: the first eligible index searching upward (with wrap) from last-granted+1. If none is eligible, park on the last-granted master (hgrant unchanged).
- FSM states:
  - ARB: evaluate the selection each cycle with hready = 1. The winner's hgrant is asserted the next cycle; go to ADDR. Re-arbitration in ARB is allowed every cycle.
  - ADDR: wait for the first beat, i.e. a cycle with hready = 1 and htrans = NONSEQ (2'b10).
    - Load beat counter from hburst: SINGLE = 1; INCR4/WRAP4 = 4; INCR8/WRAP8 = 8; INCR16/WRAP16 = 16; INCR = 0, meaning unbounded.
    - Counter 1 → back to ARB. Otherwise → BURST.
    - If htrans = IDLE with hready = 1 → back to ARB.
  - BURST: on each cycle with hready = 1 and htrans = SEQ, decrement the counter. Reaching 1 → ARB; the grant is re-evaluated in the same cycle as the last-beat accept.
    - BUSY (2'b01) holds the counter.
    - IDLE or NONSEQ with hready = 1 is an early termination → ARB.
    - INCR (counter 0): leave only on IDLE or NONSEQ.
  - LOCK: entered from ADDR/BURST completion when hlock[hmaster] = 1. Grant is held on the same master regardless of other requests, and the FIFO masks are ignored for that master. Exit to ARB on the first hready-high cycle with hlock[hmaster] = 0.
- hgrant changes only on a clock edge where hready = 1; with hready = 0 every output and the pointer freeze.
- hmaster <= index(hgrant) and hmastlock <= hlock[index(hgrant)] on every hready-high edge. hmaster therefore trails hgrant by one accepted cycle (AHB address-phase handoff).
- The round-robin pointer updates to the winner only when the grant actually changes to a new requesting master. Parking does not move it.
- Simultaneous events:
  - wfull rising while a write burst is in progress does not revoke the grant. Masks apply at arbitration only.
  - Request drop during ADDR before NONSEQ → ARB on the next hready-high cycle.
- Arithmetic: the beat counter is 5 bits, unsigned, with no wrap; decrement is only applied while counter > 1.
- Reset mid-burst: immediate return to reset values; no partial-state retention.

Test Plan:
- Reset then idle: hbusreq = 0 → hgrant = 4'b0001, hmaster = 0, hmastlock = 0, held for 10 cycles.
- Round robin: hbusreq = 4'b1111 (all reads), rempty = 0, SINGLE transfers with hready = 1 → grant order 0, 1, 2, 3, 0; hmaster follows one cycle later.
- FIFO masking: master 1 write, master 2 read, wfull = 1, rempty = 0, pointer at 1 → master 2 granted. Deassert wfull → master 1 granted at the next arbitration.
- INCR8 burst by master 0 with hbusreq = 4'b0011: grant stays on 0 for 8 SEQ/NONSEQ beats. Insert 2 BUSY cycles and 3 hready = 0 cycles → no extra beats counted; grant moves to 1 in the cycle of the 8th accept.
- Early termination: INCR16, htrans = IDLE after beat 5 → ARB; grant moves to the next eligible master.
- Lock and reset: hlock[3] = 1 with all requests high → grant is held on 3 across 3 bursts and hmastlock = 1. Assert hreset mid-burst → outputs return to reset values within the same cycle.
